// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared FSM state type and standard CRC constants
package crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_WAIT,
    ST_PROCESS,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam logic [7:0]  CRC8_POLY           = 8'h07;
  localparam logic [7:0]  CRC8_XOR_OUT        = 8'h00;
  localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_XOR_OUT = 16'h0000;
  localparam logic [31:0] CRC32_POLY          = 32'h04C11DB7;
  localparam logic [31:0] CRC32_XOR_OUT       = 32'hFFFFFFFF;

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - one-byte MSB-first CRC division step
module crc_byte_step #(
  parameter int              CRC_W      = 16,
  parameter logic [CRC_W-1:0] POLY      = 16'h1021,
  parameter bit              REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [7:0]       data_byte,
  output logic [CRC_W-1:0] next_crc
);

  logic [7:0]       b;
  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    b  = data_byte;
    c  = crc;
    fb = 1'b0;
    if (REFLECT_IN) begin
      for (int i = 0; i < 8; i++) b[i] = data_byte[7-i];
    end
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ b[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    next_crc = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - fetches a byte stream from word memory and computes its CRC
import crc_pkg::*;

module crc_stream_engine #(
  parameter int               CRC_W       = 16,
  parameter logic [CRC_W-1:0] POLY        = 16'h1021,
  parameter int               DATA_W      = 32,
  parameter int               ADDR_W      = 8,
  parameter int               LEN_W       = 16,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CRC_W-1:0]  seed,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc,
  output logic [LEN_W-1:0]  byte_count,
  output logic [15:0]       cycle_count
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t            state, state_nx;
  logic [CRC_W-1:0]  crc_reg, crc_step, crc_final;
  logic [LEN_W-1:0]  len_q, byte_count_inc;
  logic [ADDR_W-1:0] base_q, word_idx;
  logic [DATA_W-1:0] word_q;
  logic [LANE_W-1:0] lane;
  logic              last_lane, last_byte;

  function automatic logic [CRC_W-1:0] reflect_crc(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  crc_byte_step #(
    .CRC_W      (CRC_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc       (crc_reg),
    .data_byte (word_q[DATA_W-1 -: 8]),
    .next_crc  (crc_step)
  );

  assign byte_count_inc = byte_count + LEN_W'(1);
  assign last_byte      = (byte_count_inc == len_q);
  assign last_lane      = (lane == LANE_W'(BYTES - 1));
  assign crc_final      = (REFLECT_OUT ? reflect_crc(crc_reg) : crc_reg) ^ XOR_OUT;

  assign busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign done     = (state == ST_DONE);
  assign mem_rd   = (state == ST_FETCH);
  assign mem_addr = base_q + word_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_INIT;
      // decide on the length being latched this cycle
      ST_INIT:    state_nx = (length == '0) ? ST_FINAL : ST_FETCH;
      ST_FETCH:   state_nx = ST_WAIT;
      ST_WAIT:    if (mem_rvalid) state_nx = ST_PROCESS;
      ST_PROCESS: begin
        if (last_byte)      state_nx = ST_FINAL;
        else if (last_lane) state_nx = ST_FETCH;
      end
      ST_FINAL:   state_nx = ST_DONE;
      ST_DONE:    if (!start) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort && busy) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg     <= '0;
      crc         <= '0;
      len_q       <= '0;
      base_q      <= '0;
      word_idx    <= '0;
      word_q      <= '0;
      lane        <= '0;
      byte_count  <= '0;
      cycle_count <= '0;
    end else if (!(abort && busy)) begin
      if (state != ST_IDLE && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      case (state)
        ST_INIT: begin
          crc_reg     <= seed;
          len_q       <= length;
          base_q      <= base_addr;
          word_idx    <= '0;
          byte_count  <= '0;
          cycle_count <= '0;
        end
        ST_WAIT: if (mem_rvalid) begin
          word_q <= mem_rdata;
          lane   <= '0;
        end
        ST_PROCESS: begin
          crc_reg    <= crc_step;
          byte_count <= byte_count_inc;
          word_q     <= word_q << 8;
          lane       <= lane + LANE_W'(1);
          if (last_lane) word_idx <= word_idx + ADDR_W'(1);
        end
        ST_FINAL: crc <= crc_final;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16, CRC register width (8..32).
REQ-002 SHALL have parameter POLY, default 16'h1021, generator polynomial (implicit top bit).
REQ-003 SHALL have parameters DATA_W, default 32, memory word width (multiple of 8, 8..64); ADDR_W, default 8, word address width; LEN_W, default 16, byte-length width.
REQ-004 SHALL have parameters REFLECT_IN, default 0, per-byte input bit reversal; REFLECT_OUT, default 0, final CRC bit reversal; XOR_OUT, default 0, final XOR mask (CRC_W bits).
REQ-005 SHALL have ports in this order: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports start  in  1  launch request; abort  in  1  cancel current job; seed  in  CRC_W  initial CRC; length  in  LEN_W  job byte count; base_addr  in  ADDR_W  first word address.
REQ-007 SHALL have ports mem_rd  out  1  one-cycle read strobe; mem_addr  out  ADDR_W  read word address; mem_rdata  in  DATA_W  read data; mem_rvalid  in  1  read data valid.
REQ-008 SHALL have ports busy  out  1  job active; done  out  1  result valid; crc  out  CRC_W  result; byte_count  out  LEN_W  bytes consumed; cycle_count  out  16  cycles spent in non-IDLE states.

Function
REQ-009 SHALL implement FSM states IDLE, INIT, FETCH, WAIT, PROCESS, FINAL, DONE.
REQ-010 IDLE->INIT SHALL occur on start=1; INIT SHALL latch seed/length/base_addr, clear byte_count and cycle_count, load crc register with seed, last one cycle.
REQ-011 INIT->FINAL if latched length==0, else INIT->FETCH.
REQ-012 FETCH SHALL assert mem_rd=1 for exactly one cycle with mem_addr=base_addr+word index (mod 2^ADDR_W), then go to WAIT.
REQ-013 WAIT SHALL hold until mem_rvalid=1, latch mem_rdata, go to PROCESS; mem_rvalid outside WAIT SHALL be ignored.
REQ-014 PROCESS SHALL consume one byte per cycle, lane order MSB-first (byte 0 = bits DATA_W-1..DATA_W-8), incrementing byte_count per byte.
REQ-015 PROCESS SHALL exit to FINAL when byte_count reaches length (partial last word: remaining lanes skipped), else to FETCH after last lane of the word.
REQ-016 Byte update SHALL be MSB-first polynomial division of CRC_W bits by POLY, with byte bit-reversed first when REFLECT_IN=1.
REQ-017 FINAL (one cycle) SHALL set crc = (REFLECT_OUT ? reverse(reg) : reg) XOR XOR_OUT, then go to DONE.
REQ-018 DONE SHALL hold done=1 and crc stable until start=0, then go to IDLE; crc SHALL retain value in IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE and DONE.
REQ-020 start while busy SHALL be ignored.
REQ-021 abort=1 in any busy state SHALL return to IDLE next cycle without asserting done; abort SHALL have priority over all other transitions; abort in IDLE/DONE SHALL be ignored.
REQ-022 cycle_count SHALL saturate at 16'hFFFF.
REQ-023 Latency with zero-wait memory (rvalid the cycle after mem_rd): done rises 3 + N_words*2 + length cycles after start is sampled.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, mem_rd=0, busy=0, done=0, crc=0, byte_count=0, cycle_count=0, mid-job included.
REQ-025 First job after reset release SHALL behave identically to any other.

Structure
REQ-026 Shared package crc_pkg SHALL hold the FSM state enum and named POLY/XOR_OUT constants for CRC-8, CRC-16/CCITT, CRC-32.
REQ-027 Combinational byte update SHALL be a sub-module crc_byte_step (params CRC_W, POLY, REFLECT_IN; in crc, byte; out next crc).

Verification
REQ-028 CRC_W=16, POLY=16'h1021, seed=16'hFFFF, "123456789" packed 32'h31323334,32'h35363738,32'h39xxxxxx, length=9 -> crc=16'h29B1, byte_count=9, 3 reads.
REQ-029 CRC_W=32, POLY=32'h04C11DB7, REFLECT_IN=REFLECT_OUT=1, XOR_OUT=32'hFFFFFFFF, seed=32'hFFFFFFFF, same data -> crc=32'hCBF43926.
REQ-030 length=0, seed=16'hABCD, defaults -> no mem_rd, done after INIT+FINAL, crc=16'hABCD.
REQ-031 REQ-028 job with mem_rvalid delayed 3 cycles per read -> same crc, done 9 cycles later than zero-wait run.
REQ-032 abort asserted in second PROCESS cycle -> IDLE next cycle, done never 1; then restart REQ-028 -> crc=16'h29B1.
REQ-033 rst asserted in WAIT -> all outputs zero next cycle; late mem_rvalid ignored.
